dsp_prog_seq: RTL and testbench

- Upstream instruction sequencer for the dsp datapath.
- Holds a small loadable program memory of {opcode, mem_addr, imm_val} words.
- On start, steps through the program and drives each instruction onto the dsp's opcode/mem_addr/imm_val inputs for a fixed number of cycles.
- Signals completion so a controller or bench can run whole programs instead of hand-driving the dsp.

---
 rtl/dsp_prog_seq.sv | 150 +++++++++++++++
 tb/tb_dsp_prog_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_prog_seq.sv
// dsp_prog_seq
// Instruction sequencer that feeds the dsp datapath from a small program memory.
// A program of {opcode, mem_addr, imm_val} words is loaded while idle. On start
// the words are replayed in address order, each held on the outputs for
// HOLD_CYCLES cycles. A one-cycle done pulse marks the end of the run.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rstn       synchronous active-low reset (program memory is not cleared)
//   prog_we    program write enable, only acted on while idle
//   prog_addr  program write address
//   prog_data  instruction word: [10:8] opcode, [7:4] mem_addr, [3:0] imm_val
//   start      run request, only acted on while idle
//   prog_len   number of instructions to run, clamped to the memory depth
//   opcode     instruction opcode to the dsp
//   mem_addr   instruction memory address to the dsp
//   imm_val    instruction immediate to the dsp
//   issue      high on the first cycle a new instruction is presented
//   busy       run in progress
//   done       one-cycle pulse after the last instruction's hold period
//   pc         index of the instruction currently presented
module dsp_prog_seq #(
  parameter int AW          = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [10:0]   prog_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [2:0]    opcode,
  output logic [3:0]    mem_addr,
  output logic [3:0]    imm_val,
  output logic          issue,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc
);

  localparam int          DEPTH       = 2 ** AW;
  localparam logic [AW:0] MAX_LEN     = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE     = (AW + 1)'(1);
  localparam logic [AW-1:0] PC_ONE    = AW'(1);
  localparam logic [3:0]  HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t          state_q;
  logic [10:0]     progMem [DEPTH];
  logic [10:0]     instr_q;
  logic [AW-1:0]   pc_q;
  logic [AW:0]     len_q;
  logic [3:0]      holdCnt_q;
  logic            issue_q;
  logic            busy_q;
  logic            done_q;

  logic [AW:0]     clampedLen;
  logic [AW-1:0]   pcNext;
  logic            isLast;

  // Requests longer than the memory simply run the whole memory once.
  assign clampedLen = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign pcNext     = pc_q + PC_ONE;
  assign isLast     = ({1'b0, pc_q} == (len_q - LEN_ONE));

  // Program memory has no reset so a loaded program survives rstn, even mid-run.
  // Writes are only accepted while idle; a write in the same cycle as start is
  // still seen by the run because the first read happens one edge later.
  always_ff @(posedge clk) begin
    if (rstn && (state_q == IDLE) && prog_we) begin
      progMem[prog_addr] <= prog_data;
    end
  end

  // Main sequencer. A zero-length run enters DONE with done still low and raises
  // it one cycle later, so done always trails the start by at least one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      pc_q      <= '0;
      len_q     <= '0;
      holdCnt_q <= '0;
      issue_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          issue_q <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            len_q <= clampedLen;
            pc_q  <= '0;
            if (clampedLen == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
            end
          end
        end
        FETCH: begin
          instr_q   <= progMem[pc_q];
          issue_q   <= 1'b1;
          holdCnt_q <= HOLD_RELOAD;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (holdCnt_q != '0) begin
            holdCnt_q <= holdCnt_q - 4'd1;
            issue_q   <= 1'b0;
          end else if (isLast) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            issue_q <= 1'b0;
          end else begin
            pc_q      <= pcNext;
            instr_q   <= progMem[pcNext];
            issue_q   <= 1'b1;
            holdCnt_q <= HOLD_RELOAD;
          end
        end
        DONE: begin
          issue_q <= 1'b0;
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opcode   = instr_q[10:8];
  assign mem_addr = instr_q[7:4];
  assign imm_val  = instr_q[3:0];
  assign issue    = issue_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_dsp_prog_seq.sv
// tb_dsp_prog_seq
// Self-checking bench for dsp_prog_seq. A cycle-by-cycle reference derived from
// the run timing (instruction i shows at start+1+i*H, done at start+1+len*H)
// is compared against the DUT for directed, table-driven and random runs.
module tb_dsp_prog_seq;

  localparam int AW    = 4;
  localparam int H     = 3;
  localparam int DEPTH = 16;

  // Opcode numbering assumed for the dsp instruction set.
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_STO = 3'd5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [10:0]   prog_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic [2:0]    opcode;
  logic [3:0]    mem_addr;
  logic [3:0]    imm_val;
  logic          issue;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  always #5 clk = ~clk;

  dsp_prog_seq #(.AW(AW), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rstn(rstn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .prog_len(prog_len),
    .opcode(opcode), .mem_addr(mem_addr), .imm_val(imm_val),
    .issue(issue), .busy(busy), .done(done), .pc(pc)
  );

  typedef struct {
    logic [AW:0] progLen;
    int          expIssues;
    int          expDoneOff;
  } vec_t;

  vec_t        vecs[7];
  logic [10:0] refMem[DEPTH];
  logic [10:0] refOut;
  logic [10:0] issuedQ[$];
  int          nChecks = 0;
  int          nFails  = 0;

  function automatic logic [10:0] mk(input logic [2:0] op, input logic [3:0] a, input logic [3:0] imm);
    return {op, a, imm};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at cycle offset %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [10:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    refMem[a] = d;
  endtask

  // Runs one program from IDLE and checks every cycle until back in IDLE.
  // Optionally writes a word together with start, and optionally drives a
  // start+write intrusion during the run (which must be ignored).
  task automatic runProgram(input logic [AW:0] plen,
                            input bit wrWithStart, input logic [AW-1:0] wa, input logic [10:0] wd,
                            input int intrudeAt, input logic [AW-1:0] ia, input logic [10:0] id,
                            output int nIssue, output int doneAt);
    int          effLen;
    int          idx;
    logic [10:0] prevOut;
    logic [10:0] expOut;
    logic [AW-1:0] expPc;
    bit          expIssue, expBusy, expDone;
    effLen  = (int'(plen) > DEPTH) ? DEPTH : int'(plen);
    prevOut = refOut;
    expOut  = refOut;
    nIssue  = 0;
    doneAt  = -1;
    issuedQ.delete();
    if (wrWithStart) begin
      prog_we    = 1'b1;
      prog_addr  = wa;
      prog_data  = wd;
      refMem[wa] = wd;
    end
    start    = 1'b1;
    prog_len = plen;
    tick();
    for (int t = 0; t <= effLen * H + 2; t++) begin
      if (t > 0) tick();
      start   = 1'b0;
      prog_we = 1'b0;
      if (effLen == 0) begin
        expOut = prevOut; expPc = '0; expIssue = 0; expBusy = 0; expDone = (t == 1);
      end else if (t == 0) begin
        expOut = prevOut; expPc = '0; expIssue = 0; expBusy = 1; expDone = 0;
      end else begin
        idx = (t - 1) / H;
        if (idx > effLen - 1) idx = effLen - 1;
        expOut   = refMem[idx];
        expPc    = AW'(idx);
        expIssue = ((t - 1) % H == 0) && ((t - 1) / H < effLen);
        expBusy  = (t <= effLen * H);
        expDone  = (t == effLen * H + 1);
      end
      checkOutput("instr", t, 32'({opcode, mem_addr, imm_val}), 32'(expOut));
      checkOutput("pc",    t, 32'(pc),    32'(expPc));
      checkOutput("issue", t, 32'(issue), 32'(expIssue));
      checkOutput("busy",  t, 32'(busy),  32'(expBusy));
      checkOutput("done",  t, 32'(done),  32'(expDone));
      if (issue) begin
        nIssue++;
        issuedQ.push_back({opcode, mem_addr, imm_val});
      end
      if (done && doneAt < 0) doneAt = t;
      if (t == intrudeAt) begin
        start     = 1'b1;
        prog_len  = 5'd7;
        prog_we   = 1'b1;
        prog_addr = ia;
        prog_data = id;
      end
    end
    refOut = expOut;
  endtask

  initial begin
    int nIss, dOff, effLen, intr;
    logic [AW:0] rl;
    rstn = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; prog_len = '0;
    refOut = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 'x;
    tick(); tick();

    // Reset values
    checkOutput("rst_instr", 0, 32'({opcode, mem_addr, imm_val}), 32'd0);
    checkOutput("rst_pc",    0, 32'(pc),    32'd0);
    checkOutput("rst_issue", 0, 32'(issue), 32'd0);
    checkOutput("rst_busy",  0, 32'(busy),  32'd0);
    checkOutput("rst_done",  0, 32'(done),  32'd0);
    rstn = 1'b1;
    tick();

    // Four-instruction program
    applyStimulus(4'd0, mk(OP_STO, 4'd0, 4'd4));
    applyStimulus(4'd1, mk(OP_ADD, 4'd0, 4'd6));
    applyStimulus(4'd2, mk(OP_STO, 4'd1, 4'd7));
    applyStimulus(4'd3, mk(OP_SUB, 4'd1, 4'd5));
    runProgram(5'd4, 0, '0, '0, -1, '0, '0, nIss, dOff);
    checkOutput("s1_issues", 0, 32'(nIss), 32'd4);
    checkOutput("s1_done",   0, 32'(dOff), 32'd13);
    checkOutput("s1_w0", 0, 32'(issuedQ.size() > 0 ? issuedQ[0] : 11'h7ff), 32'(mk(OP_STO, 4'd0, 4'd4)));
    checkOutput("s1_w1", 0, 32'(issuedQ.size() > 1 ? issuedQ[1] : 11'h7ff), 32'(mk(OP_ADD, 4'd0, 4'd6)));
    checkOutput("s1_w2", 0, 32'(issuedQ.size() > 2 ? issuedQ[2] : 11'h7ff), 32'(mk(OP_STO, 4'd1, 4'd7)));
    checkOutput("s1_w3", 0, 32'(issuedQ.size() > 3 ? issuedQ[3] : 11'h7ff), 32'(mk(OP_SUB, 4'd1, 4'd5)));
    checkOutput("s1_hold_last", 0, 32'({opcode, mem_addr, imm_val}), 32'(mk(OP_SUB, 4'd1, 4'd5)));

    // Zero-length run
    runProgram(5'd0, 0, '0, '0, -1, '0, '0, nIss, dOff);
    checkOutput("s2_issues", 0, 32'(nIss), 32'd0);
    checkOutput("s2_done",   0, 32'(dOff), 32'd1);

    // start + write during a run are both ignored
    runProgram(5'd4, 0, '0, '0, 5, 4'd2, mk(OP_OR, 4'd15, 4'd15), nIss, dOff);
    checkOutput("s4_issues", 0, 32'(nIss), 32'd4);
    checkOutput("s4_done",   0, 32'(dOff), 32'd13);
    runProgram(5'd4, 0, '0, '0, -1, '0, '0, nIss, dOff);
    checkOutput("s4_mem2", 0, 32'(issuedQ.size() > 2 ? issuedQ[2] : 11'h7ff), 32'(mk(OP_STO, 4'd1, 4'd7)));

    // Reset in the middle of a run, then rerun from retained memory
    start = 1'b1; prog_len = 5'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checkOutput("mid_rst_instr", 5, 32'({opcode, mem_addr, imm_val}), 32'd0);
    checkOutput("mid_rst_pc",    5, 32'(pc),    32'd0);
    checkOutput("mid_rst_issue", 5, 32'(issue), 32'd0);
    checkOutput("mid_rst_busy",  5, 32'(busy),  32'd0);
    checkOutput("mid_rst_done",  5, 32'(done),  32'd0);
    refOut = '0;
    runProgram(5'd4, 0, '0, '0, -1, '0, '0, nIss, dOff);
    checkOutput("s5_w0", 0, 32'(issuedQ.size() > 0 ? issuedQ[0] : 11'h7ff), 32'(mk(OP_STO, 4'd0, 4'd4)));
    checkOutput("s5_w3", 0, 32'(issuedQ.size() > 3 ? issuedQ[3] : 11'h7ff), 32'(mk(OP_SUB, 4'd1, 4'd5)));
    checkOutput("s5_done", 0, 32'(dOff), 32'd13);

    // Table-driven lengths over a full memory of distinct words
    for (int i = 0; i < DEPTH; i++) applyStimulus(AW'(i), mk(3'(i % 8), 4'(i), 4'(15 - i)));
    vecs[0] = '{5'd4,  4,  13};
    vecs[1] = '{5'd0,  0,  1};
    vecs[2] = '{5'd20, 16, 49};
    vecs[3] = '{5'd1,  1,  4};
    vecs[4] = '{5'd16, 16, 49};
    vecs[5] = '{5'd17, 16, 49};
    vecs[6] = '{5'd2,  2,  7};
    for (int v = 0; v < 7; v++) begin
      runProgram(vecs[v].progLen, 0, '0, '0, -1, '0, '0, nIss, dOff);
      checkOutput("vec_issues", v, 32'(nIss), 32'(vecs[v].expIssues));
      checkOutput("vec_done",   v, 32'(dOff), 32'(vecs[v].expDoneOff));
    end

    // Write and start on the same edge
    runProgram(5'd1, 1, 4'd0, mk(OP_OR, 4'd3, 4'd9), -1, '0, '0, nIss, dOff);
    checkOutput("s6_word", 0, 32'(issuedQ.size() > 0 ? issuedQ[0] : 11'h7ff), 32'(mk(OP_OR, 4'd3, 4'd9)));
    checkOutput("s6_done", 0, 32'(dOff), 32'd4);

    // Random programs, lengths and intrusions
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 3; w++) applyStimulus(AW'($urandom_range(0, DEPTH - 1)), 11'($urandom));
      rl     = 5'($urandom_range(0, 20));
      effLen = (int'(rl) > DEPTH) ? DEPTH : int'(rl);
      intr   = (effLen > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, effLen * H)) : -1;
      runProgram(rl, 0, '0, '0, intr, AW'($urandom_range(0, DEPTH - 1)), 11'($urandom), nIss, dOff);
      checkOutput("rnd_issues", r, 32'(nIss), 32'(effLen));
      checkOutput("rnd_done",   r, 32'(dOff), 32'(effLen == 0 ? 1 : effLen * H + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
